// File: rtl/tap_tempo_detector_pkg.sv
// Shared constants and state encoding for the tap tempo detector.
// Cycles-per-minute default matches the beat-clock generator's clock.
package tap_tempo_detector_pkg;

    localparam longint unsigned CLK_PERIOD_REAL = 64'd6_000_000_000;
    localparam int unsigned     BPM_MIN         = 30;
    localparam int unsigned     HIST_DEPTH      = 4;

    typedef enum logic [1:0] {
        TT_IDLE  = 2'd0,
        TT_COUNT = 2'd1,
        TT_DIV   = 2'd2
    } tt_state_e;

endpackage

// File: rtl/tap_tempo_detector_serial_divider.sv
// Restoring divider, one quotient bit per cycle, DVD_W cycles per division.
// done_o marks the final iteration; quotient_o/remainder_o are valid alongside it.
module tap_tempo_detector_serial_divider #(
    parameter int DVD_W = 15,
    parameter int DSR_W = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DSR_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o,
    output logic [DSR_W-1:0] remainder_o
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DSR_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DSR_W-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    iter_q, iter_d;
    logic             busy_q, busy_d;
    logic [DSR_W:0]   trial;
    logic [DSR_W:0]   diff;
    logic [DSR_W-1:0] rem_step;
    logic [DVD_W-1:0] quo_step;
    logic             last;

    always_comb begin
        trial = {rem_q, quo_q[DVD_W-1]};
        diff  = trial - {1'b0, dsr_q};
        // remainder < divisor, so a set top bit of diff can only mean a borrow
        if (!diff[DSR_W]) begin
            rem_step = diff[DSR_W-1:0];
            quo_step = {quo_q[DVD_W-2:0], 1'b1};
        end else begin
            rem_step = trial[DSR_W-1:0];
            quo_step = {quo_q[DVD_W-2:0], 1'b0};
        end
        last = busy_q && (iter_q == CW'(1));
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        iter_d = iter_q;
        busy_d = busy_q;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dsr_d  = divisor_i;
            iter_d = CW'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            iter_d = iter_q - CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = last;
    assign quotient_o  = quo_step;
    assign remainder_o = rem_step;

endmodule

// File: rtl/tap_tempo_detector.sv
// Tap-to-bpm measurement: interval counter, 4-deep interval history,
// and a serial divide of CYCLES_PER_MIN*n by the summed intervals.
//
// state    | meaning
// TT_IDLE  | no reference tap held
// TT_COUNT | reference tap held, interval counting, timeout armed
// TT_DIV   | divider running, counter still counting, taps go to pending
module tap_tempo_detector #(
    parameter longint unsigned CYCLES_PER_MIN = tap_tempo_detector_pkg::CLK_PERIOD_REAL,
    parameter int unsigned     BPM_MIN        = tap_tempo_detector_pkg::BPM_MIN,
    parameter int unsigned     CNT_W          = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tap_i,
    output logic [7:0] bpm_o,
    output logic       bpm_valid_o,
    output logic       bpm_update_o,
    output logic       sat_o,
    output logic       busy_o
);

    import tap_tempo_detector_pkg::*;

    localparam int DIV_W = $clog2(4 * CYCLES_PER_MIN + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(CYCLES_PER_MIN / longint'(BPM_MIN));
    localparam logic [DIV_W-1:0] CPM         = DIV_W'(CYCLES_PER_MIN);

    tt_state_e                             state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [HIST_DEPTH-1:0][CNT_W-1:0]      hist_q, hist_d;
    logic [SUM_W-1:0]                      sum_q, sum_d;
    logic [2:0]                            n_q, n_d;
    logic                                  pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]                      pend_q, pend_d;
    logic [7:0]                            bpm_q, bpm_d;
    logic                                  valid_q, valid_d;
    logic                                  upd_q, upd_d;
    logic                                  sat_q, sat_d;

    logic                                  push;
    logic [CNT_W-1:0]                      push_val;
    logic                                  div_start;
    logic [DIV_W-1:0]                      div_dividend;
    logic [SUM_W-1:0]                      div_divisor;
    logic                                  div_busy;
    logic                                  div_done;
    logic [DIV_W-1:0]                      div_quo;
    logic [SUM_W-1:0]                      div_rem_unused;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hist_d       = hist_q;
        sum_d        = sum_q;
        n_d          = n_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        bpm_d        = bpm_q;
        valid_d      = valid_q;
        upd_d        = 1'b0;
        sat_d        = 1'b0;
        push         = 1'b0;
        push_val     = cnt_q;

        if (tap_i) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            TT_IDLE: begin
                if (tap_i) begin
                    state_d = TT_COUNT;
                end
            end
            TT_COUNT: begin
                if (tap_i) begin
                    push    = 1'b1;
                    state_d = TT_DIV;
                end else if (cnt_q > TIMEOUT_CNT) begin
                    state_d = TT_IDLE;
                    hist_d  = '0;
                    sum_d   = '0;
                    n_d     = '0;
                end
            end
            TT_DIV: begin
                if (tap_i) begin
                    pend_valid_d = 1'b1;
                    pend_d       = cnt_q;
                end
                if (div_done) begin
                    valid_d = 1'b1;
                    upd_d   = 1'b1;
                    if (div_quo > DIV_W'(255)) begin
                        bpm_d = 8'hFF;
                        sat_d = 1'b1;
                    end else begin
                        bpm_d = div_quo[7:0];
                    end
                    // a tap landing on the last divide cycle is the newest pending interval
                    if (tap_i || pend_valid_q) begin
                        push         = 1'b1;
                        push_val     = tap_i ? cnt_q : pend_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = TT_COUNT;
                    end
                end
            end
            default: state_d = TT_IDLE;
        endcase

        if (push) begin
            hist_d = {hist_q[HIST_DEPTH-2:0], push_val};
            sum_d  = sum_q + SUM_W'(push_val) - SUM_W'(hist_q[HIST_DEPTH-1]);
            n_d    = (n_q == 3'(HIST_DEPTH)) ? n_q : n_q + 3'd1;
        end

        div_start    = push;
        div_dividend = CPM * DIV_W'(n_d);
        div_divisor  = sum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TT_IDLE;
            cnt_q        <= '0;
            hist_q       <= '0;
            sum_q        <= '0;
            n_q          <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            bpm_q        <= '0;
            valid_q      <= 1'b0;
            upd_q        <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hist_q       <= hist_d;
            sum_q        <= sum_d;
            n_q          <= n_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            bpm_q        <= bpm_d;
            valid_q      <= valid_d;
            upd_q        <= upd_d;
            sat_q        <= sat_d;
        end
    end

    tap_tempo_detector_serial_divider #(
        .DVD_W(DIV_W),
        .DSR_W(SUM_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .remainder_o(div_rem_unused)
    );

    assign bpm_o        = bpm_q;
    assign bpm_valid_o  = valid_q;
    assign bpm_update_o = upd_q;
    assign sat_o        = sat_q;
    assign busy_o       = div_busy;

endmodule

// File: tb/tb_tap_tempo_detector.sv
// Bench for tap_tempo_detector: per-cycle comparison against a tap-event model,
// directed tap schedules with hand-computed results, then random tap streams.
module tb_tap_tempo_detector;

    localparam longint unsigned CPM   = 64'd6000;
    localparam int unsigned     BMIN  = 30;
    localparam int              DIV_W = 15;
    localparam int              TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tap = 1'b0;
    logic [7:0] bpm;
    logic       bpm_valid, bpm_update, sat, busy;

    tap_tempo_detector #(
        .CYCLES_PER_MIN(CPM),
        .BPM_MIN       (BMIN),
        .CNT_W         (28)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tap_i       (tap),
        .bpm_o       (bpm),
        .bpm_valid_o (bpm_valid),
        .bpm_update_o(bpm_update),
        .sat_o       (sat),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    bit m_live = 0;
    int m_mode = 0;          // 0 no reference tap, 1 measuring, 2 dividing
    int m_last = 0;
    int m_hist[$];
    bit m_pend = 0;
    int m_pend_iv = 0;
    int m_done_at = 0;
    int m_result = 0;
    int e_bpm = 0;
    bit e_valid = 0, e_upd = 0, e_sat = 0, e_busy = 0;

    function automatic void m_start(input int iv, input int c);
        int sum;
        sum = 0;
        m_hist.push_front(iv);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        foreach (m_hist[i]) sum += m_hist[i];
        m_result  = (int'(CPM) * m_hist.size()) / sum;
        m_done_at = c + DIV_W;
        m_mode    = 2;
    endfunction

    always @(posedge clk) begin
        int c;
        int iv;
        c = cyc;
        cyc++;
        if (rst) begin
            m_live = 1;
            m_mode = 0;
            m_hist.delete();
            m_pend = 0;
            e_bpm = 0; e_valid = 0; e_upd = 0; e_sat = 0; e_busy = 0;
        end else if (m_live) begin
            iv = c - m_last;
            e_upd = 0;
            e_sat = 0;
            case (m_mode)
                0: if (tap) m_mode = 1;
                1: begin
                    if (tap) m_start(iv, c);
                    else if (iv > TMO) begin
                        m_mode = 0;
                        m_hist.delete();
                    end
                end
                default: begin
                    if (tap) begin
                        m_pend = 1;
                        m_pend_iv = iv;
                    end
                    if (c == m_done_at) begin
                        e_upd = 1;
                        e_valid = 1;
                        if (m_result > 255) begin
                            e_bpm = 255;
                            e_sat = 1;
                        end else begin
                            e_bpm = m_result;
                        end
                        if (m_pend) begin
                            m_pend = 0;
                            m_start(m_pend_iv, c);
                        end else begin
                            m_mode = 1;
                        end
                    end
                end
            endcase
            if (tap) m_last = c;
            e_busy = (m_mode == 2);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("bpm", int'(bpm), e_bpm);
            check("bpm_valid", int'(bpm_valid), int'(e_valid));
            check("bpm_update", int'(bpm_update), int'(e_upd));
            check("sat", int'(sat), int'(e_sat));
            check("busy", int'(busy), int'(e_busy));
        end
    end

    // ---------------- update monitor for directed checks ----------------
    int sched_base = 0;
    int upd_t[$];
    int upd_b[$];
    int upd_s[$];

    always @(negedge clk) begin
        if (bpm_update) begin
            upd_t.push_back(cyc - sched_base);
            upd_b.push_back(int'(bpm));
            upd_s.push_back(int'(sat));
        end
    end

    int s_bpm, s_valid, s_busy;

    task automatic cycle(input bit t);
        tap = t;
        @(posedge clk);
        #1;
        tap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0);
        rst = 1'b0;
    endtask

    task automatic run_sched(input int taps[$], input int rst_at, input int len, input int snap_at);
        upd_t.delete();
        upd_b.delete();
        upd_s.delete();
        sched_base = cyc;
        for (int k = 0; k < len; k++) begin
            tap = 1'b0;
            foreach (taps[i]) if (taps[i] == k) tap = 1'b1;
            rst = (k == rst_at);
            @(posedge clk);
            #1;
            if (k == snap_at) begin
                s_bpm   = int'(bpm);
                s_valid = int'(bpm_valid);
                s_busy  = int'(busy);
            end
        end
        tap = 1'b0;
        rst = 1'b0;
    endtask

    task automatic check_upd(input string name, input int idx, input int t, input int b, input int s);
        if (idx >= upd_t.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: update %0d missing, got %0d updates", name, idx, upd_t.size());
        end else begin
            check({name, "_cycle"}, upd_t[idx], t);
            check({name, "_bpm"}, upd_b[idx], b);
            check({name, "_sat"}, upd_s[idx], s);
        end
    endtask

    initial begin
        int q[$];
        int gap;
        int sel;

        rst = 1'b1;
        tap = 1'b0;
        @(posedge clk);
        #1;
        check("reset_bpm", int'(bpm), 0);
        check("reset_valid", int'(bpm_valid), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // taps 0,100 -> 60 bpm at cycle 116; busy from cycle 101
        q = '{0, 100};
        run_sched(q, -1, 140, 100);
        check("s1_busy_at_101", s_busy, 1);
        check("s1_count", upd_t.size(), 1);
        check_upd("s1", 0, 116, 60, 0);
        check("s1_valid", int'(bpm_valid), 1);

        // intervals 50,50,60,60 -> 6000/50, 12000/100, 18000/160, 24000/220
        do_reset();
        q = '{0, 50, 100, 160, 220};
        run_sched(q, -1, 260, -1);
        check_upd("s2a", 0, 66, 120, 0);
        check_upd("s2b", 1, 116, 120, 0);
        check_upd("s2c", 2, 176, 112, 0);
        check_upd("s2d", 3, 236, 109, 0);

        // timeout after 60 bpm, value held; restart with n=1
        do_reset();
        q = '{0, 100, 400, 500};
        run_sched(q, -1, 540, 350);
        check("s3_held_bpm", s_bpm, 60);
        check("s3_held_valid", s_valid, 1);
        check("s3_count", upd_t.size(), 2);
        check_upd("s3b", 1, 516, 60, 0);

        // 6000/20 = 300 saturates
        do_reset();
        q = '{0, 20};
        run_sched(q, -1, 60, -1);
        check_upd("s4", 0, 36, 255, 1);

        // third tap during divide becomes pending, restarts right after
        do_reset();
        q = '{0, 100, 110};
        run_sched(q, -1, 160, 115);
        check_upd("s5a", 0, 116, 60, 0);
        check("s5_busy_at_116", s_busy, 1);
        check_upd("s5b", 1, 131, 109, 0);

        // reset in the middle of a divide after a valid result
        do_reset();
        q = '{0, 100, 200};
        run_sched(q, 205, 300, 205);
        check("s6_bpm", s_bpm, 0);
        check("s6_valid", s_valid, 0);
        check("s6_busy", s_busy, 0);
        check("s6_count", upd_t.size(), 1);
        check_upd("s6a", 0, 116, 60, 0);

        // random tap streams
        do_reset();
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      gap = $urandom_range(1, 20);
            else if (sel < 8) gap = $urandom_range(20, 210);
            else              gap = $urandom_range(195, 300);
            repeat (gap - 1) cycle(1'b0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                cycle(1'b0);
                rst = 1'b0;
            end
            cycle(1'b1);
        end
        repeat (40) cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
